// File: rtl/uart_pkt_parser_pkg.sv
// Shared types and constants for the UART packet parser: FSM states, error codes and
// default framing parameters.
package uart_pkt_parser_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0]  DEFAULT_SOF     = 8'hA5;
  localparam int unsigned DEFAULT_MAX_LEN = 16;
  localparam int unsigned BYTE_W          = 8;

  // Counter/pointer width for a range of 'depth' values, never narrower than 1 bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: DEPTH x 8 register array with one synchronous write port and one
// combinational read port. Out-of-range accesses are ignored / read as zero.
module uart_pkt_buf
  import uart_pkt_parser_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_MAX_LEN,
  parameter int unsigned AW    = ptr_width(DEFAULT_MAX_LEN)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [BYTE_W-1:0] rd_data_c
);

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_c = '0;
    if (32'(rd_addr) < DEPTH) begin
      rd_data_c = mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_pkt_parser.sv
// Frame parser behind the UART receiver: finds SOF, validates LEN and checksum, buffers
// the payload and replays good frames on a valid/ready byte stream.
module uart_pkt_parser
  import uart_pkt_parser_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned BAUD_RATE      = 9600,
  parameter logic [7:0]  SOF            = DEFAULT_SOF,
  parameter int unsigned MAX_LEN        = DEFAULT_MAX_LEN,
  parameter int unsigned TIMEOUT_CYCLES = 30 * CLK_FREQ / BAUD_RATE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  pkt_data,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic        pkt_last,
  output logic [7:0]  pkt_len,
  output logic        frm_ok,
  output logic        frm_err,
  output logic [1:0]  err_code,
  output logic        overrun,
  output logic        busy
);

  localparam int unsigned PTR_W  = ptr_width(MAX_LEN);
  localparam int unsigned TCNT_W = ptr_width(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);

  state_t              state, state_nxt;
  logic                rx_valid_q;
  logic [7:0]          sum, sum_nxt;
  logic [PTR_W-1:0]    wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]    rd_ptr, rd_ptr_nxt;
  logic [TCNT_W-1:0]   tcnt, tcnt_nxt;
  logic [7:0]          pkt_data_nxt, pkt_len_nxt;
  logic                pkt_valid_nxt, pkt_last_nxt;
  logic                frm_ok_nxt, frm_err_nxt, overrun_nxt, busy_nxt;
  logic [1:0]          err_code_nxt;

  logic                stb_c, timed_c, tmo_c, xfer_c, wr_en_c;
  logic [PTR_W-1:0]    rd_addr_c;
  logic [7:0]          rd_data_c;

  // A byte is consumed only on the rising edge of the receiver's valid level.
  always_comb begin
    stb_c     = rx_valid & ~rx_valid_q;
    timed_c   = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
    tmo_c     = timed_c & ~stb_c & (tcnt == TCNT_LAST);
    xfer_c    = pkt_valid & pkt_ready;
    wr_en_c   = (state == ST_PAYLOAD) & stb_c;
    rd_addr_c = xfer_c ? (rd_ptr + PTR_W'(1)) : rd_ptr;
  end

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (PTR_W)
  ) u_buf (
    .clk       (clk),
    .wr_en     (wr_en_c),
    .wr_addr   (wr_ptr),
    .wr_data   (rx_data),
    .rd_addr   (rd_addr_c),
    .rd_data_c (rd_data_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt     = state;
    sum_nxt       = sum;
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    tcnt_nxt      = '0;
    pkt_data_nxt  = pkt_data;
    pkt_len_nxt   = pkt_len;
    pkt_valid_nxt = pkt_valid;
    pkt_last_nxt  = pkt_last;
    frm_ok_nxt    = 1'b0;
    frm_err_nxt   = 1'b0;
    err_code_nxt  = err_code;
    overrun_nxt   = 1'b0;

    if (timed_c) begin
      tcnt_nxt = stb_c ? '0 : (tcnt + TCNT_W'(1));
    end

    case (state)
      ST_HUNT: begin
        if (stb_c && (rx_data == SOF)) begin
          state_nxt = ST_LEN;
        end
      end

      ST_LEN: begin
        if (stb_c) begin
          if ((rx_data != 8'd0) && (rx_data <= MAX_LEN_B)) begin
            pkt_len_nxt = rx_data;
            sum_nxt     = rx_data;
            wr_ptr_nxt  = '0;
            state_nxt   = ST_PAYLOAD;
          end else begin
            frm_err_nxt  = 1'b1;
            err_code_nxt = ERR_LEN;
            state_nxt    = ST_HUNT;
          end
        end else if (tmo_c) begin
          frm_err_nxt  = 1'b1;
          err_code_nxt = ERR_TMO;
          state_nxt    = ST_HUNT;
        end
      end

      ST_PAYLOAD: begin
        if (stb_c) begin
          sum_nxt    = 8'(sum + rx_data);
          wr_ptr_nxt = wr_ptr + PTR_W'(1);
          if (8'(wr_ptr) == (pkt_len - 8'd1)) begin
            state_nxt = ST_CHK;
          end
        end else if (tmo_c) begin
          frm_err_nxt  = 1'b1;
          err_code_nxt = ERR_TMO;
          state_nxt    = ST_HUNT;
        end
      end

      ST_CHK: begin
        if (stb_c) begin
          if (8'(sum + rx_data) == 8'h00) begin
            frm_ok_nxt    = 1'b1;
            pkt_valid_nxt = 1'b1;
            pkt_data_nxt  = rd_data_c;
            pkt_last_nxt  = (pkt_len == 8'd1);
            rd_ptr_nxt    = '0;
            state_nxt     = ST_DRAIN;
          end else begin
            frm_err_nxt  = 1'b1;
            err_code_nxt = ERR_CHK;
            state_nxt    = ST_HUNT;
          end
        end else if (tmo_c) begin
          frm_err_nxt  = 1'b1;
          err_code_nxt = ERR_TMO;
          state_nxt    = ST_HUNT;
        end
      end

      ST_DRAIN: begin
        overrun_nxt = stb_c;
        if (xfer_c) begin
          if (pkt_last) begin
            pkt_valid_nxt = 1'b0;
            pkt_last_nxt  = 1'b0;
            rd_ptr_nxt    = '0;
            state_nxt     = ST_HUNT;
          end else begin
            rd_ptr_nxt   = rd_addr_c;
            pkt_data_nxt = rd_data_c;
            pkt_last_nxt = ((8'(rd_ptr) + 8'd1) == (pkt_len - 8'd1));
          end
        end
      end

      default: begin
        state_nxt = ST_HUNT;
      end
    endcase

    busy_nxt = (state_nxt != ST_HUNT);
  end

  // rx_valid_q resets high so a valid level held across reset is not a new byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_HUNT;
      rx_valid_q <= 1'b1;
      sum        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tcnt       <= '0;
      pkt_data   <= '0;
      pkt_len    <= '0;
      pkt_valid  <= 1'b0;
      pkt_last   <= 1'b0;
      frm_ok     <= 1'b0;
      frm_err    <= 1'b0;
      err_code   <= ERR_NONE;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      rx_valid_q <= rx_valid;
      sum        <= sum_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      tcnt       <= tcnt_nxt;
      pkt_data   <= pkt_data_nxt;
      pkt_len    <= pkt_len_nxt;
      pkt_valid  <= pkt_valid_nxt;
      pkt_last   <= pkt_last_nxt;
      frm_ok     <= frm_ok_nxt;
      frm_err    <= frm_err_nxt;
      err_code   <= err_code_nxt;
      overrun    <= overrun_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Scoreboard bench for uart_pkt_parser: stimulus pushes expected events built from the
// frame rules, a monitor pops and compares every pulse and every payload transfer.
module tb_uart_pkt_parser;

  localparam int unsigned TMO  = 64;
  localparam int unsigned MAXL = 16;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_ready;
  logic       pkt_last;
  logic [7:0] pkt_len;
  logic       frm_ok;
  logic       frm_err;
  logic [1:0] err_code;
  logic       overrun;
  logic       busy;

  uart_pkt_parser #(
    .MAX_LEN        (MAXL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_last  (pkt_last),
    .pkt_len   (pkt_len),
    .frm_ok    (frm_ok),
    .frm_err   (frm_err),
    .err_code  (err_code),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {EV_OK, EV_ERR, EV_OVR, EV_BYTE} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    logic       last;
    logic [7:0] len;
    logic [1:0] code;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad   = 0;
  int  ready_mode = 0;  // 0 random, 1 held low, 2 held high

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input logic [7:0] d, input logic l,
                         input logic [7:0] n, input logic [1:0] c);
    ev_t e;
    e.kind = k; e.data = d; e.last = l; e.len = n; e.code = c;
    sb.push_back(e);
  endtask

  task automatic take(input ev_kind_t k, output ev_t e, output bit ok);
    total++;
    ok = 1'b0;
    e.kind = EV_OK; e.data = '0; e.last = 1'b0; e.len = '0; e.code = '0;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL event: unexpected kind %0d with empty scoreboard at %0t", k, $time);
    end else begin
      e = sb.pop_front();
      if (e.kind != k) begin
        bad++;
        $display("FAIL event: got kind %0d want kind %0d at %0t", k, e.kind, $time);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Monitor: sample DUT outputs on the falling edge.
  initial begin
    ev_t e;
    bit  ok;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (frm_err) begin
          take(EV_ERR, e, ok);
          if (ok) check("err_code", 32'(err_code), 32'(e.code));
        end
        if (frm_ok) take(EV_OK, e, ok);
        if (overrun) take(EV_OVR, e, ok);
        if (pkt_valid && pkt_ready) begin
          take(EV_BYTE, e, ok);
          if (ok) begin
            check("pkt_data", 32'(pkt_data), 32'(e.data));
            check("pkt_last", 32'(pkt_last), 32'(e.last));
            check("pkt_len",  32'(pkt_len),  32'(e.len));
          end
        end
      end
    end
  end

  // Consumer ready, changed away from the sampling edge.
  initial begin
    pkt_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       pkt_ready = 1'($urandom_range(0, 1));
        1:       pkt_ready = 1'b0;
        default: pkt_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  function automatic logic [7:0] chk_of(input logic [7:0] n, input logic [7:0] pay[$]);
    int s;
    s = int'(n);
    foreach (pay[i]) s += int'(pay[i]);
    return 8'(256 - (s % 256));
  endfunction

  task automatic expect_good(input logic [7:0] pay[$]);
    push_ev(EV_OK, 8'h00, 1'b0, 8'h00, 2'b00);
    foreach (pay[i]) push_ev(EV_BYTE, pay[i], (i == pay.size() - 1), 8'(pay.size()), 2'b00);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0 || busy) begin
      bad++;
      $display("FAIL wait_idle: pending=%0d busy=%0b after %0d cycles", sb.size(), busy, n);
      sb.delete();
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] pay[$];
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_pkt_valid", 32'(pkt_valid), 0);
    check("rst_pkt_len",   32'(pkt_len),   0);
    check("rst_busy",      32'(busy),      0);
    check("rst_err_code",  32'(err_code),  0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Leading garbage then a good 3-byte frame.
    pay = '{8'h11, 8'h22, 8'h33};
    expect_good(pay);
    q = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_bytes(q);
    wait_idle(200);

    // Bad checksum.
    push_ev(EV_ERR, 8'h00, 1'b0, 8'h00, 2'b10);
    q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    send_bytes(q);
    wait_idle(200);

    // LEN zero and LEN above the maximum.
    push_ev(EV_ERR, 8'h00, 1'b0, 8'h00, 2'b01);
    push_ev(EV_ERR, 8'h00, 1'b0, 8'h00, 2'b01);
    q = '{8'hA5, 8'h00, 8'hA5, 8'h11};
    send_bytes(q);
    wait_idle(200);

    // Timeout mid-payload, then a 1-byte frame whose payload and CHK equal SOF-ish values.
    push_ev(EV_ERR, 8'h00, 1'b0, 8'h00, 2'b11);
    q = '{8'hA5, 8'h02, 8'h10};
    send_bytes(q);
    wait_idle(4 * TMO);
    check("tmo_err_code", 32'(err_code), 32'(2'b11));
    pay = '{8'h5A};
    expect_good(pay);
    q = '{8'hA5, 8'h01, 8'h5A, 8'hA5};
    send_bytes(q);
    wait_idle(200);

    // Backpressure during drain plus an overrun byte.
    ready_mode = 1;
    push_ev(EV_OK, 8'h00, 1'b0, 8'h00, 2'b00);
    push_ev(EV_OVR, 8'h00, 1'b0, 8'h00, 2'b00);
    push_ev(EV_BYTE, 8'h11, 1'b0, 8'h03, 2'b00);
    push_ev(EV_BYTE, 8'h22, 1'b0, 8'h03, 2'b00);
    push_ev(EV_BYTE, 8'h33, 1'b1, 8'h03, 2'b00);
    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_bytes(q);
    repeat (3) @(negedge clk);
    check("bp_valid", 32'(pkt_valid), 1);
    check("bp_data",  32'(pkt_data),  32'h11);
    send_byte(8'h42);
    repeat (2) @(negedge clk);
    check("bp_data_hold", 32'(pkt_data), 32'h11);
    check("bp_last_hold", 32'(pkt_last), 0);
    check("bp_len_hold",  32'(pkt_len),  3);
    ready_mode = 2;
    wait_idle(200);
    ready_mode = 0;

    // Reset mid-payload with rx_valid held high across release.
    q = '{8'hA5, 8'h04, 8'h11};
    send_bytes(q);
    @(negedge clk);
    rx_data = 8'h22; rx_valid = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_len",   32'(pkt_len),   0);
    check("mid_rst_busy",  32'(busy),      0);
    check("mid_rst_code",  32'(err_code),  0);
    check("mid_rst_pulse", 32'({frm_ok, frm_err, overrun, pkt_valid, pkt_last}), 0);
    check("mid_rst_data",  32'(pkt_data),  0);
    rx_data = 8'hA5;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_no_stb", 32'(busy), 0);
    rx_valid = 1'b0;
    pay = '{8'h5A};
    expect_good(pay);
    q = '{8'hA5, 8'h01, 8'h5A, 8'hA5};
    send_bytes(q);
    wait_idle(200);

    // Randomized frames checked against the frame rules.
    for (int f = 0; f < 40; f++) begin
      automatic int kind = $urandom_range(0, 9);
      automatic logic [7:0] n = 8'($urandom_range(1, MAXL));
      pay = {};
      q = {};
      for (int i = 0; i < int'(n); i++) pay.push_back(8'($urandom_range(0, 255)));
      if (kind == 9) begin
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
          automatic logic [7:0] g = 8'($urandom_range(0, 255));
          q.push_back((g == 8'hA5) ? 8'h00 : g);
        end
      end
      if (kind == 7) begin
        n = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255));
        push_ev(EV_ERR, 8'h00, 1'b0, 8'h00, 2'b01);
        q.push_back(8'hA5);
        q.push_back(n);
        send_bytes(q);
        wait_idle(200);
      end else if (kind == 8) begin
        automatic int k = $urandom_range(0, int'(n));
        push_ev(EV_ERR, 8'h00, 1'b0, 8'h00, 2'b11);
        q.push_back(8'hA5);
        q.push_back(n);
        for (int i = 0; i < k; i++) q.push_back(pay[i]);
        send_bytes(q);
        wait_idle(4 * TMO);
      end else begin
        q.push_back(8'hA5);
        q.push_back(n);
        foreach (pay[i]) q.push_back(pay[i]);
        if (kind == 6) begin
          q.push_back(8'(chk_of(n, pay) + 8'($urandom_range(1, 255))));
          push_ev(EV_ERR, 8'h00, 1'b0, 8'h00, 2'b10);
        end else begin
          q.push_back(chk_of(n, pay));
          expect_good(pay);
        end
        send_bytes(q);
        wait_idle(400);
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
